stack_queue_calc: RTL and testbench

Top-level 32-entry, 16-bit RPN-style calculator. Switch values are pushed into a single storage buffer that acts as a LIFO stack or a FIFO queue depending on a mode input. Arithmetic buttons remove two operands and write the result back. The result is driven to the seven-segment display path, and full/empty status goes to LEDs.

---
 rtl/stack_queue_calc_pkg.sv | 30 +++
 rtl/stack_queue_calc_if.sv | 12 +
 rtl/sq_mem_ctrl.sv | 148 ++++++++++++++
 rtl/stack_queue_calc.sv | 91 +++++++++
 tb/tb_stack_queue_calc.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/stack_queue_calc_pkg.sv
// Shared types and constants for the stack/queue RPN calculator.
package stack_queue_calc_pkg;

  localparam int unsigned DEPTH   = 32;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned NUM_OP  = 4;

  localparam int unsigned BTN_PUSH = 0;
  localparam int unsigned BTN_ADD  = 1;
  localparam int unsigned BTN_SUB  = 2;
  localparam int unsigned BTN_POP  = 3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD1, ST_RM1, ST_RD2, ST_RM2, ST_CALC, ST_WR, ST_DONE
  } state_e;

  typedef enum logic [1:0] {OP_PUSH, OP_ADD, OP_SUB, OP_POP} op_e;

  // Fixed priority among simultaneous button edges: push > add > sub > pop.
  function automatic op_e btn_to_op(input logic [NUM_OP-1:0] e);
    if (e[BTN_PUSH])     return OP_PUSH;
    else if (e[BTN_ADD]) return OP_ADD;
    else if (e[BTN_SUB]) return OP_SUB;
    else                 return OP_POP;
  endfunction

endpackage

// File: rtl/stack_queue_calc_if.sv
// Board-facing signal bundle of the calculator: mode, switches, buttons, display, LEDs.
interface stack_queue_calc_if #(parameter int unsigned WIDTH = 16);
  logic             stackQueue;
  logic [WIDTH-1:0] switches;
  logic [4:0]       btns;
  logic [WIDTH-1:0] sseg;
  logic             empty;
  logic             full;

  modport master (output stackQueue, switches, btns, input sseg, empty, full);
  modport slave  (input stackQueue, switches, btns, output sseg, empty, full);
endinterface

// File: rtl/sq_mem_ctrl.sv
// Shared LIFO/FIFO storage with pointers, count, operation FSM and add/sub ALU.
module sq_mem_ctrl
  import stack_queue_calc_pkg::*;
#(
  parameter int unsigned DEPTH = stack_queue_calc_pkg::DEPTH,
  parameter int unsigned WIDTH = stack_queue_calc_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  op_e              op_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] sseg_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] memory [DEPTH];

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             mode_q, mode_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sseg_q, sseg_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             we_c, remove_c;
  logic [PW-1:0]    rd_addr_c;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mode_d    = mode_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    sseg_d    = sseg_q;
    we_c      = 1'b0;
    remove_c  = 1'b0;
    rd_addr_c = mode_q ? head_q : tail_q - PW'(1);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d   = op_i;
          mode_d = mode_i;
          case (op_i)
            OP_PUSH: if (!full_q) begin
              res_d   = wdata_i;
              state_d = ST_WR;
            end
            OP_POP:  if (!empty_q) state_d = ST_RD1;
            default: if (count_q >= CW'(2)) state_d = ST_RD1;
          endcase
        end
      end
      ST_RD1: state_d = ST_RM1;
      ST_RM1: begin
        remove_c = 1'b1;
        a_d      = rd_data_q;
        if (op_q == OP_POP) begin
          sseg_d  = rd_data_q;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD2;
        end
      end
      ST_RD2: state_d = ST_RM2;
      ST_RM2: begin
        remove_c = 1'b1;
        b_d      = rd_data_q;
        state_d  = ST_CALC;
      end
      ST_CALC: begin
        res_d   = (op_q == OP_SUB) ? a_q - b_q : a_q + b_q;
        state_d = ST_WR;
      end
      ST_WR: begin
        we_c    = 1'b1;
        tail_d  = tail_q + PW'(1);
        count_d = count_q + CW'(1);
        sseg_d  = res_q;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Stack removes from the tail side, queue from the head side.
    if (remove_c) begin
      count_d = count_q - CW'(1);
      if (mode_q) head_d = head_q + PW'(1);
      else        tail_d = tail_q - PW'(1);
    end

    empty_d   = (count_d == CW'(0));
    full_d    = (count_d == CW'(DEPTH));
    rd_data_d = memory[rd_addr_c];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_PUSH;
      mode_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sseg_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sseg_q  <= sseg_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (we_c) memory[tail_q] <= res_q;
  end

  assign sseg_o  = sseg_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/stack_queue_calc.sv
// Calculator top: button conditioning, rising-edge detect and storage controller.
// STACK_QUEUE_CALC_DEBOUNCE_EN adds a synchronizer + 2^20-cycle debouncer per button.
module stack_queue_calc
  import stack_queue_calc_pkg::*;
#(
  parameter int unsigned DEPTH = stack_queue_calc_pkg::DEPTH,
  parameter int unsigned WIDTH = stack_queue_calc_pkg::WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  stack_queue_calc_if.slave   io
);

  logic [NUM_OP-1:0] btn_clean_c;
  logic [NUM_OP-1:0] btn_prev_q, btn_prev_d;
  logic [NUM_OP-1:0] edge_q, edge_d;
  logic              btn_unused_c;
  op_e               op_c;

  assign btn_unused_c = io.btns[NUM_BTN-1];

`ifdef STACK_QUEUE_CALC_DEBOUNCE_EN
  localparam int unsigned DB_CNT_W = 20;

  for (genvar i = 0; i < NUM_OP; i++) begin : g_db
    logic [1:0]          sync_q, sync_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic                stable_q, stable_d;

    // Accept a new level only after it has differed from the current one for 2^20 cycles.
    always_comb begin
      sync_d   = {sync_q[0], io.btns[i]};
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync_q[1] == stable_q) begin
        cnt_d = '0;
      end else if (&cnt_q) begin
        cnt_d    = '0;
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        sync_q   <= '0;
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        sync_q   <= sync_d;
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign btn_clean_c[i] = stable_q;
  end
`else
  assign btn_clean_c = io.btns[NUM_OP-1:0];
`endif

  always_comb begin
    btn_prev_d = btn_clean_c;
    edge_d     = btn_clean_c & ~btn_prev_q;
    op_c       = btn_to_op(edge_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_prev_q <= '0;
      edge_q     <= '0;
    end else begin
      btn_prev_q <= btn_prev_d;
      edge_q     <= edge_d;
    end
  end

  sq_mem_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) m1 (
    .clk     (clk),
    .rst     (rst),
    .start_i (|edge_q),
    .op_i    (op_c),
    .mode_i  (io.stackQueue),
    .wdata_i (io.switches),
    .sseg_o  (io.sseg),
    .empty_o (io.empty),
    .full_o  (io.full)
  );

endmodule

// File: tb/tb_stack_queue_calc.sv
// Scoreboard bench for stack_queue_calc: directed scenarios plus random button traffic vs a deque model.
module tb_stack_queue_calc;
  import stack_queue_calc_pkg::*;

  typedef struct {
    logic [15:0] sseg;
    logic        empty;
    logic        full;
    int          count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stack_queue_calc_if #(.WIDTH(16)) bus ();
  stack_queue_calc dut (.clk(clk), .rst(rst), .io(bus));

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] model[$];
  logic [15:0] m_sseg;
  logic        sample_req = 1'b0;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_remove(input logic mode);
    if (mode) return model.pop_front();
    else      return model.pop_back();
  endfunction

  task automatic push_expect();
    exp_t e;
    e.sseg  = m_sseg;
    e.empty = (model.size() == 0);
    e.full  = (model.size() == 32);
    e.count = model.size();
    exp_q.push_back(e);
  endtask

  task automatic model_op(input logic [4:0] b, input logic mode, input logic [15:0] sw);
    logic [15:0] a, c, r;
    if (b[0]) begin
      if (model.size() < 32) begin
        model.push_back(sw);
        m_sseg = sw;
      end
    end else if (b[1] || b[2]) begin
      if (model.size() >= 2) begin
        a = model_remove(mode);
        c = model_remove(mode);
        r = b[1] ? a + c : a - c;
        model.push_back(r);
        m_sseg = r;
      end
    end else if (b[3]) begin
      if (model.size() > 0) m_sseg = model_remove(mode);
    end
    push_expect();
  endtask

  task automatic sample();
    @(posedge clk);
    #1 sample_req = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 sample_req = 1'b0;
  endtask

  task automatic press(input logic [4:0] b, input logic mode, input logic [15:0] sw, input int hold);
    @(posedge clk);
    #1;
    bus.btns       = b;
    bus.stackQueue = mode;
    bus.switches   = sw;
    model_op(b, mode, sw);
    repeat (hold) @(posedge clk);
    #1 bus.btns = 5'b0;
    repeat (10) @(posedge clk);
    sample();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.btns = 5'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    model.delete();
    m_sseg = 16'h0;
    push_expect();
    sample();
  endtask

  // Monitor: compare DUT status against the oldest expectation whenever a sample is presented.
  always @(negedge clk) begin
    if (sample_req) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: sample with no expectation at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sseg",  bus.sseg,  mon_e.sseg);
        chk("empty", bus.empty, mon_e.empty);
        chk("full",  bus.full,  mon_e.full);
        chk("count", dut.m1.count_q, mon_e.count);
      end
    end
  end

  initial begin
    int r;
    logic [4:0] b;
    bus.btns       = 5'b0;
    bus.stackQueue = 1'b0;
    bus.switches   = 16'h0;
    repeat (2) @(posedge clk);
    do_reset();

    // Stack fill, then a push while full must leave storage untouched.
    for (int i = 1; i <= 32; i++) press(5'b00001, 1'b0, 16'(i), 2);
    for (int i = 0; i < 32; i++) chk("stack_fill_mem", dut.m1.memory[i], i + 1);
    press(5'b00001, 1'b0, 16'hAAAA, 2);
    for (int i = 0; i < 32; i++) chk("push_full_mem", dut.m1.memory[i], i + 1);

    // Stack add chain down to one entry; the extra add is ignored.
    for (int k = 1; k <= 31; k++) press(5'b00010, 1'b0, 16'h0, 10);
    chk("add_chain_final", bus.sseg, 528);
    press(5'b00010, 1'b0, 16'h0, 10);
    chk("add_ignored", bus.sseg, 528);

    // Queue fill and head-side adds.
    do_reset();
    for (int i = 1; i <= 32; i++) press(5'b00001, 1'b1, 16'(i), 2);
    for (int i = 0; i < 32; i++) chk("queue_fill_mem", dut.m1.memory[i], i + 1);
    press(5'b00010, 1'b1, 16'h0, 2);
    chk("queue_add1", bus.sseg, 3);
    chk("queue_tail_entry", dut.m1.memory[0], 3);
    press(5'b00010, 1'b1, 16'h0, 2);
    chk("queue_add2", bus.sseg, 7);
    press(5'b00010, 1'b1, 16'h0, 2);
    chk("queue_add3", bus.sseg, 11);

    // Pop when empty, subtract order, add wrap-around.
    do_reset();
    press(5'b01000, 1'b0, 16'h0, 2);
    press(5'b00001, 1'b0, 16'd5, 2);
    press(5'b00001, 1'b0, 16'd9, 2);
    press(5'b00100, 1'b0, 16'h0, 2);
    chk("sub_9_minus_5", bus.sseg, 4);
    do_reset();
    press(5'b00001, 1'b0, 16'hFFFF, 2);
    press(5'b00001, 1'b0, 16'h0002, 2);
    press(5'b00010, 1'b0, 16'h0, 2);
    chk("add_wrap", bus.sseg, 16'h0001);

    // Reset in the middle of an add aborts it at the next edge.
    do_reset();
    press(5'b00001, 1'b0, 16'd3, 2);
    press(5'b00001, 1'b0, 16'd4, 2);
    @(posedge clk);
    #1 bus.btns = 5'b00010;
    @(posedge clk);
    #1 bus.btns = 5'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_count", dut.m1.count_q, 0);
    chk("midrst_empty", bus.empty, 1);
    chk("midrst_sseg",  bus.sseg, 0);
    chk("midrst_state", 32'(dut.m1.state_q), 32'(ST_IDLE));
    rst = 1'b1;
    model.delete();
    m_sseg = 16'h0;

    // Random traffic with mode changes and simultaneous presses.
    do_reset();
    repeat (300) begin
      r = $urandom_range(0, 99);
      if (r < 40)      b = 5'b00001;
      else if (r < 55) b = 5'b00010;
      else if (r < 70) b = 5'b00100;
      else if (r < 90) b = 5'b01000;
      else             b = 5'($urandom_range(0, 31));
      press(b, 1'($urandom_range(0, 1)), 16'($urandom()), $urandom_range(1, 4));
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
